// File: rtl/truth_table_prober.sv
// Drives every {x,y} combination into a 2-input combinational block, captures z
// after SETTLE clocks per point, and compares the captured table to a golden one.
module truth_table_prober #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       areset,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] expected,
    input  logic       z,
    output logic       x,
    output logic       y,
    output logic [3:0] table_o,   // "table" is a reserved word in SystemVerilog
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DONE
    } state_t;

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    state_t     state_q;
    logic [1:0] idx_q;
    logic [7:0] cnt_q;
    logic       x_q;
    logic       y_q;
    logic [3:0] exp_q;
    logic [3:0] tbl_q;
    logic [3:0] tbl_d;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [7:0] err_q;

    always_comb begin
        tbl_d        = tbl_q;
        tbl_d[idx_q] = z;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 8'd0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            exp_q   <= 4'd0;
            tbl_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        exp_q   <= expected;
                        tbl_q   <= 4'd0;
                        pass_q  <= 1'b0;
                        idx_q   <= 2'd0;
                        x_q     <= 1'b0;
                        y_q     <= 1'b0;
                        cnt_q   <= SETTLE_C;
                        busy_q  <= 1'b1;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        // Partial table is kept for debug; the sweep never counts.
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        idx_q   <= 2'd0;
                        cnt_q   <= 8'd0;
                        x_q     <= 1'b0;
                        y_q     <= 1'b0;
                    end else if (cnt_q == 8'd1) begin
                        tbl_q <= tbl_d;
                        if (idx_q == 2'd3) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            cnt_q   <= 8'd0;
                            pass_q  <= (tbl_d == exp_q);
                            if ((tbl_d != exp_q) && (err_q != 8'hFF))
                                err_q <= err_q + 8'd1;
                        end else begin
                            idx_q      <= idx_q + 2'd1;
                            {x_q, y_q} <= idx_q + 2'd1;
                            cnt_q      <= SETTLE_C;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    idx_q   <= 2'd0;
                    x_q     <= 1'b0;
                    y_q     <= 1'b0;
                    if (abort)
                        pass_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign table_o   = tbl_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_truth_table_prober.sv
// Directed bench for truth_table_prober: one instance with SETTLE=2 and one with
// SETTLE=1, both probing the block z = x | ~y (truth table 4'b1101).
module tb_truth_table_prober;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       areset;
    logic       start2, abort2, z2, x2, y2, busy2, done2, pass2;
    logic [3:0] exp2, tbl2;
    logic [7:0] err2;
    logic       start1, abort1, z1, x1, y1, busy1, done1, pass1;
    logic [3:0] exp1, tbl1;
    logic [7:0] err1;

    assign z2 = x2 | ~y2;
    assign z1 = x1 | ~y1;

    truth_table_prober #(.SETTLE(2)) dut2 (
        .clk(clk), .areset(areset), .start(start2), .abort(abort2),
        .expected(exp2), .z(z2), .x(x2), .y(y2), .table_o(tbl2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2)
    );

    truth_table_prober #(.SETTLE(1)) dut1 (
        .clk(clk), .areset(areset), .start(start1), .abort(abort1),
        .expected(exp1), .z(z1), .x(x1), .y(y1), .table_o(tbl1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        areset = 1'b1;
        start2 = 1'b0; abort2 = 1'b0; exp2 = 4'd0;
        start1 = 1'b0; abort1 = 1'b0; exp1 = 4'd0;
        tick(); tick();

        // Reset state
        chk("rst_xy",    32'({x2, y2}), 0);
        chk("rst_table", 32'(tbl2), 0);
        chk("rst_busy",  32'(busy2), 0);
        chk("rst_done",  32'(done2), 0);
        chk("rst_pass",  32'(pass2), 0);
        chk("rst_err",   32'(err2), 0);
        chk("rst_busy1", 32'(busy1), 0);
        areset = 1'b0;
        tick();

        // Passing sweep, SETTLE=2: {x,y} steps at T, T+2, T+4, T+6
        exp2 = 4'b1101; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("t1_busy", 32'(busy2), 1);
        chk("t1_xy_T", 32'({x2, y2}), 0);
        tick();
        chk("t1_xy_T1", 32'({x2, y2}), 0);
        tick();
        chk("t1_xy_T2", 32'({x2, y2}), 1);
        tick(); tick();
        chk("t1_xy_T4", 32'({x2, y2}), 2);
        tick(); tick();
        chk("t1_xy_T6", 32'({x2, y2}), 3);
        tick();
        chk("t1_done_early", 32'(done2), 0);
        tick();
        chk("t1_done",  32'(done2), 1);
        chk("t1_table", 32'(tbl2), 4'b1101);
        chk("t1_pass",  32'(pass2), 1);
        chk("t1_err",   32'(err2), 0);
        chk("t1_busy_done", 32'(busy2), 1);
        // start during the DONE cycle must be ignored
        exp2 = 4'b1001; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("t1_done_clr",  32'(done2), 0);
        chk("t1_idle",      32'(busy2), 0);
        chk("t1_table_hold", 32'(tbl2), 4'b1101);
        chk("t1_pass_hold", 32'(pass2), 1);
        tick();
        chk("t1_start_ignored", 32'(busy2), 0);

        // Failing sweep, then saturation of err_count
        exp2 = 4'b1001; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (8) tick();
        chk("t2_done",  32'(done2), 1);
        chk("t2_table", 32'(tbl2), 4'b1101);
        chk("t2_pass",  32'(pass2), 0);
        chk("t2_err",   32'(err2), 1);
        tick();
        for (int i = 0; i < 256; i++) begin
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            repeat (9) tick();
            if (i == 252) chk("t2_err_254", 32'(err2), 254);
        end
        chk("t2_err_sat",  32'(err2), 255);
        chk("t2_pass_end", 32'(pass2), 0);

        // SETTLE=1 with start held: accept, 4 samples, DONE, IDLE, accept ...
        exp1 = 4'b1101; start1 = 1'b1;
        tick();
        for (int j = 1; j <= 30; j++) begin
            tick();
            chk("t3_done", 32'(done1), 32'((j % 6) == 4));
            chk("t3_busy", 32'(busy1), 32'((j % 6) != 5));
            if ((j % 6) == 4) begin
                chk("t3_table", 32'(tbl1), 4'b1101);
                chk("t3_pass",  32'(pass1), 1);
            end
        end
        start1 = 1'b0;
        repeat (6) tick();
        chk("t3_idle", 32'(busy1), 0);

        // Abort on the edge that would sample idx=1
        exp2 = 4'b1101; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick(); tick(); tick();
        abort2 = 1'b1;
        tick();
        abort2 = 1'b0;
        chk("t4_busy",  32'(busy2), 0);
        chk("t4_xy",    32'({x2, y2}), 0);
        chk("t4_table", 32'(tbl2), 4'b0001);
        chk("t4_pass",  32'(pass2), 0);
        chk("t4_done",  32'(done2), 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t4_no_done", 32'(done2), 0);
        end
        chk("t4_err", 32'(err2), 255);

        // Abort in DONE clears pass but keeps table
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (8) tick();
        chk("t4b_pass_before", 32'(pass2), 1);
        abort2 = 1'b1;
        tick();
        abort2 = 1'b0;
        chk("t4b_pass",  32'(pass2), 0);
        chk("t4b_table", 32'(tbl2), 4'b1101);
        chk("t4b_busy",  32'(busy2), 0);
        chk("t4b_done",  32'(done2), 0);
        chk("t4b_err",   32'(err2), 255);

        // start together with abort in IDLE does nothing
        start2 = 1'b1; abort2 = 1'b1;
        tick(); tick();
        chk("t5_busy",  32'(busy2), 0);
        chk("t5_xy",    32'({x2, y2}), 0);
        chk("t5_table", 32'(tbl2), 4'b1101);
        start2 = 1'b0; abort2 = 1'b0;
        tick();

        // Asynchronous reset mid-SETTLE, then a clean sweep
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick(); tick(); tick();
        #2;
        areset = 1'b1;
        #1;
        chk("t6_xy",    32'({x2, y2}), 0);
        chk("t6_table", 32'(tbl2), 0);
        chk("t6_busy",  32'(busy2), 0);
        chk("t6_done",  32'(done2), 0);
        chk("t6_pass",  32'(pass2), 0);
        chk("t6_err",   32'(err2), 0);
        start2 = 1'b1;
        #1;
        areset = 1'b0;
        tick();
        start2 = 1'b0;
        chk("t6_restart", 32'(busy2), 1);
        repeat (8) tick();
        chk("t6_done_after", 32'(done2), 1);
        chk("t6_table_after", 32'(tbl2), 4'b1101);
        chk("t6_pass_after", 32'(pass2), 1);
        chk("t6_err_after",  32'(err2), 0);
        tick();
        chk("t6_done_pulse", 32'(done2), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
